out_fm_store: RTL and testbench

Drains the Y output_fm banks of the convolution core into the out_fm store FIFO once a tile's results are final. Reads all Y banks at one shared address and selects the bank for the current output channel, then pushes words in channel-major order (channel, row, column). Applies backpressure from the FIFO's almost-full flag. Sits between the output_fm bank array and the conv_mem_if store FIFO, and is started by the conv controller's st_result_data_start.

---
 rtl/out_fm_store_pkg.sv | 22 ++
 rtl/out_fm_store_if.sv | 24 ++
 rtl/out_fm_store_tile_addr_cnt.sv | 61 ++++++
 rtl/out_fm_store.sv | 86 ++++++++
 tb/tb_out_fm_store.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/out_fm_store_pkg.sv
// Shared conv constants for the out_fm store path: default widths, tile geometry,
// FSM state encoding and a width helper.
package out_fm_store_pkg;

    localparam int AW_DEF = 16;
    localparam int DW_DEF = 32;
    localparam int Y_DEF  = 4;
    localparam int TN_DEF = 16;
    localparam int TR_DEF = 64;
    localparam int TC_DEF = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Counter width that stays at least one bit for degenerate sizes.
    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/out_fm_store_if.sv
// Start/done handshake, output_fm bank read port and store FIFO push port.
interface out_fm_store_if #(
    parameter int AW = 16,
    parameter int DW = 32,
    parameter int Y  = 4
);
    logic          st_start;
    logic          st_done;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data [Y];
    logic [DW-1:0] fifo_data;
    logic          fifo_push;
    logic          fifo_almost_full;

    modport master (
        input  st_start, rd_data, fifo_almost_full,
        output st_done, rd_addr, fifo_data, fifo_push
    );

    modport slave (
        output st_start, rd_data, fifo_almost_full,
        input  st_done, rd_addr, fifo_data, fifo_push
    );
endinterface

// File: rtl/out_fm_store_tile_addr_cnt.sv
// Nested col/row/ch tile counters (col innermost) with last-element flag,
// bank select and linear bank address; shared with the out_fm load path.
module out_fm_store_tile_addr_cnt
    import out_fm_store_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int TN = TN_DEF,
    parameter int TR = TR_DEF,
    parameter int TC = TC_DEF,
    parameter int Y  = Y_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clr,
    input  logic              i_en,
    output logic [cw(Y)-1:0]  o_bank,
    output logic              o_last,
    output logic [AW-1:0]     o_addr
);
    localparam int CW = cw(TC);
    localparam int RW = cw(TR);
    localparam int HW = cw(TN);
    localparam int BW = cw(Y);
    localparam int YS = $clog2(Y);

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [HW-1:0] r_ch;
    logic          w_col_wrap;
    logic          w_row_wrap;
    logic [HW-1:0] w_lch;

    assign w_col_wrap = (r_col == CW'(TC - 1));
    assign w_row_wrap = (r_row == RW'(TR - 1));
    assign o_last     = w_col_wrap && w_row_wrap && (r_ch == HW'(TN - 1));
    assign w_lch      = r_ch >> YS;
    assign o_bank     = r_ch[BW-1:0];
    assign o_addr     = AW'(w_lch) * AW'(TR * TC) + AW'(r_row) * AW'(TC) + AW'(r_col);

    // The final element holds the counters; ch never wraps within a run.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_col <= '0;
            r_row <= '0;
            r_ch  <= '0;
        end else if (i_en && !o_last) begin
            if (w_col_wrap) begin
                r_col <= '0;
                if (w_row_wrap) begin
                    r_row <= '0;
                    r_ch  <= r_ch + HW'(1);
                end else begin
                    r_row <= r_row + RW'(1);
                end
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

endmodule

// File: rtl/out_fm_store.sv
// Drains the Y output_fm banks into the store FIFO in channel-major order,
// throttled by the FIFO almost-full flag.
module out_fm_store
    import out_fm_store_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF,
    parameter int Y  = Y_DEF,
    parameter int TN = TN_DEF,
    parameter int TR = TR_DEF,
    parameter int TC = TC_DEF
) (
    input  logic           i_clk,
    input  logic           i_rst,
    out_fm_store_if.master bus
);
    localparam int BW = cw(Y);

    logic [1:0]    r_state;
    logic          w_issue;
    logic          w_last;
    logic          w_clr;
    logic [BW-1:0] w_bank;
    logic [AW-1:0] w_addr;
    logic          r_s1_v;
    logic [BW-1:0] r_s1_bank;
    logic          r_push;
    logic [DW-1:0] r_data;

    assign w_issue = (r_state == ST_RUN) && !bus.fifo_almost_full;
    assign w_clr   = (r_state == ST_IDLE);

    out_fm_store_tile_addr_cnt #(
        .AW (AW),
        .TN (TN),
        .TR (TR),
        .TC (TC),
        .Y  (Y)
    ) u_cnt (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (w_clr),
        .i_en   (w_issue),
        .o_bank (w_bank),
        .o_last (w_last),
        .o_addr (w_addr)
    );

    // Stage 2 is already emptying while stage 1 clears, so leaving DRAIN on
    // stage 1 alone lands st_done in the cycle right after the last push.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (bus.st_start) r_state <= ST_RUN;
                ST_RUN:   if (w_issue && w_last) r_state <= ST_DRAIN;
                ST_DRAIN: if (!r_s1_v) r_state <= ST_DONE;
                ST_DONE:  r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_v    <= 1'b0;
            r_s1_bank <= '0;
            r_push    <= 1'b0;
            r_data    <= '0;
        end else begin
            r_s1_v    <= w_issue;
            r_s1_bank <= w_bank;
            r_push    <= r_s1_v;
            if (r_s1_v) begin
                r_data <= bus.rd_data[r_s1_bank];
            end
        end
    end

    assign bus.rd_addr   = w_addr;
    assign bus.fifo_data = r_data;
    assign bus.fifo_push = r_push;
    assign bus.st_done   = (r_state == ST_DONE);

endmodule

// File: tb/tb_out_fm_store.sv
// Scoreboard bench for out_fm_store: a small tile instance for the directed and
// random cases and a default-geometry instance for the full-size drain.
module tb_out_fm_store;

    localparam int S_Y = 4, S_TN = 4, S_TR = 2, S_TC = 2;
    localparam int S_TOT = S_TN * S_TR * S_TC;
    localparam int B_Y = 4, B_TN = 16, B_TR = 64, B_TC = 16;
    localparam int B_TOT = B_TN * B_TR * B_TC;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    out_fm_store_if #(.AW(16), .DW(32), .Y(S_Y)) s_if ();
    out_fm_store_if #(.AW(16), .DW(32), .Y(B_Y)) b_if ();

    out_fm_store #(.AW(16), .DW(32), .Y(S_Y), .TN(S_TN), .TR(S_TR), .TC(S_TC)) u_small (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (s_if)
    );

    out_fm_store #(.AW(16), .DW(32), .Y(B_Y), .TN(B_TN), .TR(B_TR), .TC(B_TC)) u_big (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (b_if)
    );

    // Bank models: bank b returns (b << shift) | addr one cycle after the address.
    always @(posedge clk) begin
        for (int b = 0; b < S_Y; b++) s_if.rd_data[b] <= (32'(b) << 8) | 32'(s_if.rd_addr);
        for (int b = 0; b < B_Y; b++) b_if.rd_data[b] <= (32'(b) << 16) | 32'(b_if.rd_addr);
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: n-th pushed word of a run, decoded from the channel-major index.
    function automatic logic [31:0] exp_word(input int n, input int tr, input int tc,
                                             input int y, input int sh);
        int ch, row, col, addr;
        ch   = n / (tr * tc);
        row  = (n / tc) % tr;
        col  = n % tc;
        addr = ((ch / y) * tr * tc + row * tc + col) % 65536;
        return (32'(ch % y) << sh) | 32'(addr);
    endfunction

    logic [31:0] exp_q[$];
    int   n_push = 0;
    int   done_cnt = 0;
    logic s_push_d1 = 1'b0;
    logic s_af_d1 = 1'b0;

    always @(posedge clk) begin
        #1;
        if (s_if.fifo_push) begin
            n_push++;
            chk("push_after_af", 32'(s_af_d1), 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_push", s_if.fifo_data, 32'hFFFF_FFFF);
            end else begin
                chk("word", s_if.fifo_data, exp_q.pop_front());
            end
        end
        if (s_if.st_done) begin
            done_cnt++;
            chk("done_after_last_push", 32'(s_push_d1 && exp_q.size() == 0), 32'd1);
        end
        s_push_d1 = s_if.fifo_push;
        s_af_d1   = s_if.fifo_almost_full;
    end

    int   b_n = 0;
    int   b_done = 0;
    logic b_af_d1 = 1'b0;

    always @(posedge clk) begin
        #1;
        if (b_if.fifo_push) begin
            chk("big_push_after_af", 32'(b_af_d1), 32'd0);
            chk("big_word", b_if.fifo_data, exp_word(b_n, B_TR, B_TC, B_Y, 16));
            if (b_n == 5 * 1024 + 3 * 16 + 2)
                chk("big_ch5_r3_c2", b_if.fifo_data, 32'h0001_0432);
            b_n++;
        end
        if (b_if.st_done) begin
            b_done++;
            chk("big_total_pushes", 32'(b_n), 32'(B_TOT));
        end
        b_af_d1 = b_if.fifo_almost_full;
    end

    task automatic start_run();
        @(negedge clk);
        s_if.st_start = 1'b1;
        for (int n = 0; n < S_TOT; n++) exp_q.push_back(exp_word(n, S_TR, S_TC, S_Y, 8));
        @(negedge clk);
        s_if.st_start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, input int pct);
        int k = 0;
        while (done_cnt == d0 && k < budget) begin
            @(negedge clk);
            if (pct > 0) s_if.fifo_almost_full = ($urandom_range(0, 99) < pct);
            k++;
        end
        s_if.fifo_almost_full = 1'b0;
        if (done_cnt == d0) chk("done_timeout", 32'd0, 32'd1);
        repeat (4) @(negedge clk);
        chk("single_done", 32'(done_cnt - d0), 32'd1);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic full_run(input string tag, input int pct);
        int p0 = n_push;
        int d0 = done_cnt;
        start_run();
        wait_done(d0, 400, pct);
        chk({tag, "_push_count"}, 32'(n_push - p0), 32'(S_TOT));
    endtask

    initial begin
        int p0, d0, k;
        s_if.st_start = 1'b0;
        s_if.fifo_almost_full = 1'b0;
        b_if.st_start = 1'b0;
        b_if.fifo_almost_full = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_rd_addr", 32'(s_if.rd_addr), 32'd0);
        chk("rst_push", 32'(s_if.fifo_push), 32'd0);
        chk("rst_data", s_if.fifo_data, 32'd0);
        chk("rst_done", 32'(s_if.st_done), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        full_run("basic", 0);

        // almost_full held for cycles 5-9 of the run
        p0 = n_push; d0 = done_cnt;
        start_run();
        repeat (3) @(negedge clk);
        s_if.fifo_almost_full = 1'b1;
        repeat (5) @(negedge clk);
        s_if.fifo_almost_full = 1'b0;
        wait_done(d0, 400, 0);
        chk("bp_push_count", 32'(n_push - p0), 32'(S_TOT));

        // almost_full exactly when the final element is due
        p0 = n_push; d0 = done_cnt;
        start_run();
        repeat (15) @(negedge clk);
        s_if.fifo_almost_full = 1'b1;
        repeat (3) @(negedge clk);
        s_if.fifo_almost_full = 1'b0;
        wait_done(d0, 400, 0);
        chk("final_af_push_count", 32'(n_push - p0), 32'(S_TOT));

        // second st_start during RUN is ignored
        p0 = n_push; d0 = done_cnt;
        start_run();
        repeat (4) @(negedge clk);
        s_if.st_start = 1'b1;
        @(negedge clk);
        s_if.st_start = 1'b0;
        wait_done(d0, 400, 0);
        chk("restart_push_count", 32'(n_push - p0), 32'(S_TOT));

        // reset after 7 pushes
        p0 = n_push; d0 = done_cnt;
        start_run();
        k = 0;
        while (n_push - p0 < 7 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("seven_pushes_seen", 32'(n_push - p0), 32'd7);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #2;
        chk("midrst_rd_addr", 32'(s_if.rd_addr), 32'd0);
        chk("midrst_push", 32'(s_if.fifo_push), 32'd0);
        chk("midrst_data", s_if.fifo_data, 32'd0);
        chk("midrst_done", 32'(s_if.st_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("midrst_no_more_push", 32'(n_push - p0), 32'd7);
        chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        full_run("after_rst", 0);

        for (int r = 0; r < 4; r++) full_run("random", 20 + 15 * r);

        // full default geometry with light random backpressure
        @(negedge clk);
        b_if.st_start = 1'b1;
        @(negedge clk);
        b_if.st_start = 1'b0;
        k = 0;
        while (b_done == 0 && k < 30000) begin
            @(negedge clk);
            b_if.fifo_almost_full = ($urandom_range(0, 99) < 10);
            k++;
        end
        b_if.fifo_almost_full = 1'b0;
        repeat (4) @(negedge clk);
        chk("big_single_done", 32'(b_done), 32'd1);
        chk("big_push_total", 32'(b_n), 32'(B_TOT));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
